// File: rtl/scroll_pkg.sv
// Shared constants, types and timing-total helpers for the parallax scroll timing block.
package scroll_pkg;

  // Default 640x480@60 timing.
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  // Pixel position counters are 10 bits, so a total may not exceed 1024.
  localparam int POS_W     = 10;
  localparam int MAX_TOTAL = 1024;

  // Per-layer speed field width in the packed speed bus.
  localparam int SPEED_W = 4;

  // Default scroll offset width and its type.
  localparam int DEF_OFS_W = 10;
  typedef logic [DEF_OFS_W-1:0] offset_t;

  // Total pixels per line including blanking.
  function automatic int h_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  // Total lines per frame including blanking.
  function automatic int v_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/scroll_offset_acc.sv
// One wrapping scroll-offset accumulator. The next-offset value is exported so the
// top can register layer_x in the same cycle the new offset becomes current.
module scroll_offset_acc
  import scroll_pkg::*;
#(
  parameter int OFS_W = DEF_OFS_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               upd_en,
  input  logic               dir,
  input  logic [SPEED_W-1:0] speed,
  output logic [OFS_W-1:0]   ofs_next
);

  logic [OFS_W-1:0] ofs_q;
  logic [OFS_W-1:0] ofs_d;
  logic [OFS_W-1:0] speed_ext;

  // Next offset: add or subtract the zero-extended speed, wrapping mod 2^OFS_W.
  always_comb begin
    speed_ext = OFS_W'(speed);
    ofs_d     = ofs_q;
    if (upd_en) begin
      if (dir) begin
        ofs_d = ofs_q - speed_ext;
      end else begin
        ofs_d = ofs_q + speed_ext;
      end
    end else begin
      ofs_d = ofs_q;
    end
  end

  // Offset register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ofs_q <= {OFS_W{1'b0}};
    end else begin
      ofs_q <= ofs_d;
    end
  end

  assign ofs_next = ofs_d;

endmodule

// File: rtl/parallax_scroll_timing.sv
// Video timing generator with per-layer parallax scroll offsets. Every output is a
// register decoded from the next counter/offset values, so all outputs describe the
// same pixel as hpos/vpos in the same cycle.
module parallax_scroll_timing
  import scroll_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter int LAYERS   = 2,
  parameter int OFS_W    = DEF_OFS_W
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      ena,
  input  logic [SPEED_W*LAYERS-1:0] speed,
  input  logic                      dir,
  input  logic                      pause,
  output logic                      hsync,
  output logic                      vsync,
  output logic                      display_on,
  output logic [POS_W-1:0]          hpos,
  output logic [POS_W-1:0]          vpos,
  output logic                      frame_tick,
  output logic [OFS_W*LAYERS-1:0]   layer_x
);

  localparam int H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  if (H_TOTAL > MAX_TOTAL || V_TOTAL > MAX_TOTAL) begin : g_bad_timing
    $error("parallax_scroll_timing: H_TOTAL/V_TOTAL exceed 1024");
  end
  if (LAYERS < 1 || LAYERS > 4) begin : g_bad_layers
    $error("parallax_scroll_timing: LAYERS must be 1..4");
  end

  localparam logic [POS_W-1:0] H_LAST   = POS_W'(H_TOTAL - 1);
  localparam logic [POS_W-1:0] V_LAST   = POS_W'(V_TOTAL - 1);
  // Decode bounds are one bit wider so an end bound of exactly 1024 is representable.
  localparam logic [POS_W:0]   H_ACT_E  = (POS_W+1)'(H_ACTIVE);
  localparam logic [POS_W:0]   HS_START = (POS_W+1)'(H_ACTIVE + H_FP);
  localparam logic [POS_W:0]   HS_END   = (POS_W+1)'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [POS_W:0]   V_ACT_E  = (POS_W+1)'(V_ACTIVE);
  localparam logic [POS_W:0]   VS_START = (POS_W+1)'(V_ACTIVE + V_FP);
  localparam logic [POS_W:0]   VS_END   = (POS_W+1)'(V_ACTIVE + V_FP + V_SYNC);

  logic [POS_W-1:0]        h_q, h_d;
  logic [POS_W-1:0]        v_q, v_d;
  logic                    hsync_q, hsync_d;
  logic                    vsync_q, vsync_d;
  logic                    display_on_q, display_on_d;
  logic                    frame_tick_q, frame_tick_d;
  logic [OFS_W*LAYERS-1:0] layer_x_q, layer_x_d;
  logic [OFS_W*LAYERS-1:0] ofs_nxt;
  logic                    upd_en;

  // Pixel/line counters: advance only when enabled, line wraps bump the line counter.
  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (ena) begin
      if (h_q == H_LAST) begin
        h_d = {POS_W{1'b0}};
        if (v_q == V_LAST) begin
          v_d = {POS_W{1'b0}};
        end else begin
          v_d = v_q + POS_W'(1);
        end
      end else begin
        h_d = h_q + POS_W'(1);
        v_d = v_q;
      end
    end else begin
      h_d = h_q;
      v_d = v_q;
    end
  end

  // Offsets move only on the edge that leaves the last pixel of a frame, so the new
  // values appear exactly at 0,0; a frozen last pixel still updates once on resume.
  always_comb begin
    upd_en = 1'b0;
    if (ena && !pause && (h_q == H_LAST) && (v_q == V_LAST)) begin
      upd_en = 1'b1;
    end else begin
      upd_en = 1'b0;
    end
  end

  for (genvar i = 0; i < LAYERS; i++) begin : g_layer
    scroll_offset_acc #(
      .OFS_W (OFS_W)
    ) u_acc (
      .clk      (clk),
      .rst_n    (rst_n),
      .upd_en   (upd_en),
      .dir      (dir),
      .speed    (speed[i*SPEED_W +: SPEED_W]),
      .ofs_next (ofs_nxt[i*OFS_W +: OFS_W])
    );
  end

  // Output decode from next-state values; when disabled the inputs to the decode hold,
  // so the decode reproduces the held outputs, except frame_tick which is forced low.
  always_comb begin
    hsync_d      = ~(({1'b0, h_d} >= HS_START) && ({1'b0, h_d} < HS_END));
    vsync_d      = ~(({1'b0, v_d} >= VS_START) && ({1'b0, v_d} < VS_END));
    display_on_d = ({1'b0, h_d} < H_ACT_E) && ({1'b0, v_d} < V_ACT_E);
    if (ena) begin
      frame_tick_d = (h_d == H_LAST) && (v_d == V_LAST);
    end else begin
      frame_tick_d = 1'b0;
    end
    layer_x_d = {(OFS_W*LAYERS){1'b0}};
    for (int i = 0; i < LAYERS; i++) begin
      layer_x_d[i*OFS_W +: OFS_W] = OFS_W'(h_d) + ofs_nxt[i*OFS_W +: OFS_W];
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_q          <= {POS_W{1'b0}};
      v_q          <= {POS_W{1'b0}};
      hsync_q      <= 1'b1;
      vsync_q      <= 1'b1;
      display_on_q <= 1'b1;
      frame_tick_q <= 1'b0;
      layer_x_q    <= {(OFS_W*LAYERS){1'b0}};
    end else begin
      h_q          <= h_d;
      v_q          <= v_d;
      hsync_q      <= hsync_d;
      vsync_q      <= vsync_d;
      display_on_q <= display_on_d;
      frame_tick_q <= frame_tick_d;
      layer_x_q    <= layer_x_d;
    end
  end

  assign hpos       = h_q;
  assign vpos       = v_q;
  assign hsync      = hsync_q;
  assign vsync      = vsync_q;
  assign display_on = display_on_q;
  assign frame_tick = frame_tick_q;
  assign layer_x    = layer_x_q;

endmodule
